div_frontend: RTL and testbench
===============================

# div_frontend

Request/response front end that sits directly upstream of the team's iterative unsigned divider core and drives its `en`/operand inputs. It accepts signed or unsigned divide requests over a valid/ready handshake. It converts signed operands to magnitudes, launches the core, and waits for its `done` pulse. It then applies sign fix-up and presents quotient and remainder over a valid/ready response port with a pass-through tag.

## Interface
- WIDTH, 32, operand/result width; must equal the core's `width` (≥2)
- TAG_W, 4, request tag width (≥1)

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low; the core shares the same rst_n
- req_valid  in  1  request present
- req_ready  out  1  front end can accept (high only in IDLE)
- req_dividend  in  WIDTH  dividend
- req_divisor  in  WIDTH  divisor
- req_signed  in  1  1 = two's-complement divide, 0 = unsigned
- req_tag  in  TAG_W  opaque tag, returned with the response
- div_en  out  1  one-cycle launch pulse to the core
- div_dividend  out  WIDTH  magnitude of dividend to the core
- div_divisor  out  WIDTH  magnitude of divisor to the core
- div_busy  in  1  core busy
- div_done  in  1  core one-cycle completion pulse
- div_result  in  WIDTH  core quotient (valid in the `div_done` cycle)
- div_rem  in  WIDTH  core remainder (valid in the `div_done` cycle)
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts
- resp_quotient  out  WIDTH  final quotient
- resp_remainder  out  WIDTH  final remainder
- resp_tag  out  TAG_W  tag of the request
- resp_divzero  out  1  divisor was zero

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- **IDLE:** `req_ready`=1. On `req_valid`, the block latches the inputs:
  - magnitudes: |x| when `req_signed` and the MSB is set, else x;
  - `neg_q` = signed & (sign(dividend) ^ sign(divisor)) & (divisor≠0);
  - `neg_r` = signed & sign(dividend);
  - `divzero` = (divisor==0);
  - tag.
  - Next state is ISSUE.
- **ISSUE:** `div_en`=1 only when `div_busy`=0; otherwise the block stalls in ISSUE. After the pulse, next state is WAIT. `div_dividend`/`div_divisor` are driven from the latched magnitudes in every state.
- **WAIT:** On `div_done`, the block captures:
  - quotient = `neg_q` ? −`div_result` : `div_result`;
  - remainder = `neg_r` ? −`div_rem` : `div_rem`.
  - Next state is RESP.
- **RESP:** `resp_valid`=1 and all response outputs are held stable. When `resp_ready`=1, next state is IDLE. A new request is not accepted in the same cycle.
- Arithmetic is modulo 2^WIDTH. Negation is two's complement in WIDTH bits.
- Most-negative / −1 yields quotient = most-negative and remainder = 0 with no extra logic; this is required.
- Divide-by-zero always yields quotient = all ones, remainder = original dividend, and `resp_divzero`=1. This holds signed and unsigned.
- `div_done` outside WAIT is ignored.

## Timing
- Reset values:
  - state IDLE;
  - `req_ready`=1 (after the reset cycle);
  - `div_en`=0, `resp_valid`=0, `resp_divzero`=0;
  - `resp_quotient`/`resp_remainder`/`resp_tag`=0;
  - `div_dividend`/`div_divisor`=0.
- Normal latency with the core idle:
  - accept at cycle T, `div_en` at T+1;
  - the core asserts `div_done` at T+WIDTH+2;
  - `resp_valid` rises at T+WIDTH+3.
- Throughput is one request per WIDTH+4 cycles minimum: one IDLE cycle after the response handshake.
- `div_en` is never high for two consecutive cycles and is never high while `div_busy`=1.
- Reset asserted in any state forces the state to IDLE within one cycle, drops `resp_valid`, and abandons the in-flight operation. The core resets from the same rst_n.
- `resp_ready` held low keeps RESP indefinitely with stable outputs.

## Configuration
- `DIVZERO_FASTPATH_EN` defined:
  - a request with divisor==0 goes IDLE→RESP directly;
  - no `div_en` is issued;
  - `resp_valid` rises at T+1 with the divide-by-zero values.
- Not defined: zero-divisor requests go through the core with normal latency. Results are identical, since the core returns all ones and the dividend, and `neg_q` is forced to 0.

## Test plan
- Unsigned 100 / 7, WIDTH=32 -> quotient 14, remainder 2; `div_en` at T+1; `resp_valid` at T+35.
- Signed −7 / 2 -> quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1); signed 7 / −2 -> −3, 1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, `resp_divzero`=0.
- Signed −5 / 0 -> quotient 0xFFFFFFFF, remainder 0xFFFFFFFB, `resp_divzero`=1. Latency is 1 cycle with `DIVZERO_FASTPATH_EN` and 35 without; no `div_en` is seen with the macro.
- Back-to-back requests with tags 3 then 9, and `resp_ready` low for 5 cycles on the first -> outputs stable; `req_ready`=0 throughout; second response carries tag 9.
- rst_n low during WAIT for 1 cycle -> `resp_valid` never asserts for that request; `req_ready`=1 the next cycle; a fresh 9 / 3 returns quotient 3, remainder 0.

Source files
------------

// File: rtl/div_frontend_if.sv
// rtl/div_frontend_if.sv - request, divider-core and response signal bundle for div_frontend
// slave is the front end's view; master is the surrounding environment's view.
interface div_frontend_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_dividend;
  logic [WIDTH-1:0] req_divisor;
  logic             req_signed;
  logic [TAG_W-1:0] req_tag;

  logic             div_en;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_result;
  logic [WIDTH-1:0] div_rem;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_quotient;
  logic [WIDTH-1:0] resp_remainder;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_divzero;

  modport slave (
    input  req_valid, req_dividend, req_divisor, req_signed, req_tag,
    input  div_busy, div_done, div_result, div_rem,
    input  resp_ready,
    output req_ready,
    output div_en, div_dividend, div_divisor,
    output resp_valid, resp_quotient, resp_remainder, resp_tag, resp_divzero
  );

  modport master (
    output req_valid, req_dividend, req_divisor, req_signed, req_tag,
    output div_busy, div_done, div_result, div_rem,
    output resp_ready,
    input  req_ready,
    input  div_en, div_dividend, div_divisor,
    input  resp_valid, resp_quotient, resp_remainder, resp_tag, resp_divzero
  );
endinterface

// File: rtl/div_frontend.sv
// rtl/div_frontend.sv - signed/unsigned request front end for the iterative unsigned divider core
// Optional DIVZERO_FASTPATH_EN: zero-divisor requests skip the core and respond the next cycle.
module div_frontend #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  div_frontend_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_mag_q, dvd_mag_d;
  logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             divzero_q, divzero_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             dvd_neg;
  logic             dvs_neg;
  logic             req_divzero;
  logic             div_en;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return '0 - x;
  endfunction

  // Sign decode of the incoming request; only meaningful for signed requests.
  always_comb begin
    dvd_neg     = bus.req_signed & bus.req_dividend[WIDTH-1];
    dvs_neg     = bus.req_signed & bus.req_divisor[WIDTH-1];
    req_divzero = (bus.req_divisor == '0);
  end

  always_comb begin
    state_d    = state_q;
    dvd_mag_d  = dvd_mag_q;
    dvs_mag_d  = dvs_mag_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    divzero_d  = divzero_q;
    tag_d      = tag_q;
    div_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          dvd_mag_d  = dvd_neg ? negate(bus.req_dividend) : bus.req_dividend;
          dvs_mag_d  = dvs_neg ? negate(bus.req_divisor) : bus.req_divisor;
          // A zero divisor keeps the quotient at all ones, so never negate it.
          neg_quot_d = (dvd_neg ^ dvs_neg) & ~req_divzero;
          neg_rem_d  = dvd_neg;
          divzero_d  = req_divzero;
          tag_d      = bus.req_tag;
`ifdef DIVZERO_FASTPATH_EN
          if (req_divzero) begin
            quot_d  = '1;
            rem_d   = bus.req_dividend;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end

      ISSUE: begin
        if (!bus.div_busy) begin
          div_en  = 1'b1;
          state_d = WAIT;
        end
      end

      WAIT: begin
        // Most-negative / -1 falls out of the magnitude path: the core returns
        // 2^(WIDTH-1), whose two's-complement negation is itself.
        if (bus.div_done) begin
          quot_d  = neg_quot_q ? negate(bus.div_result) : bus.div_result;
          rem_d   = neg_rem_q ? negate(bus.div_rem) : bus.div_rem;
          state_d = RESP;
        end
      end

      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dvd_mag_q  <= '0;
      dvs_mag_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      divzero_q  <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      dvd_mag_q  <= dvd_mag_d;
      dvs_mag_q  <= dvs_mag_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      divzero_q  <= divzero_d;
      tag_q      <= tag_d;
    end
  end

  assign bus.req_ready      = (state_q == IDLE);
  assign bus.div_en         = div_en;
  assign bus.div_dividend   = dvd_mag_q;
  assign bus.div_divisor    = dvs_mag_q;
  assign bus.resp_valid     = (state_q == RESP);
  assign bus.resp_quotient  = quot_q;
  assign bus.resp_remainder = rem_q;
  assign bus.resp_tag       = tag_q;
  assign bus.resp_divzero   = divzero_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(div_en && bus.div_busy));
    end
  end

endmodule

// File: tb/tb_div_frontend.sv
// tb/tb_div_frontend.sv - self-checking bench for div_frontend with a behavioural divider core
// Honours DIVZERO_FASTPATH_EN for the expected zero-divisor latency.
module tb_div_frontend;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int LAT   = WIDTH + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  div_frontend_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus();

  div_frontend #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Behavioural core: done arrives WIDTH+1 cycles after the en cycle.
  logic             core_busy;
  logic             core_done;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_r;
  int               core_cnt;
  logic             stall_busy = 1'b0;
  logic             stray_done = 1'b0;

  assign bus.div_busy   = core_busy | stall_busy;
  assign bus.div_done   = core_done | stray_done;
  assign bus.div_result = core_q;
  assign bus.div_rem    = core_r;

  always @(posedge clk) begin
    if (!rst_n) begin
      core_busy <= 1'b0;
      core_done <= 1'b0;
      core_cnt  <= 0;
      core_q    <= '0;
      core_r    <= '0;
    end else begin
      core_done <= 1'b0;
      if (bus.div_en && !core_busy) begin
        core_busy <= 1'b1;
        core_cnt  <= WIDTH;
        if (bus.div_divisor == '0) begin
          core_q <= '1;
          core_r <= bus.div_dividend;
        end else begin
          core_q <= bus.div_dividend / bus.div_divisor;
          core_r <= bus.div_dividend % bus.div_divisor;
        end
      end else if (core_busy) begin
        if (core_cnt == 1) begin
          core_busy <= 1'b0;
          core_done <= 1'b1;
        end
        core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa;
    longint sb;
    dz = (b == 32'd0);
    if (dz) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic int exp_latency(input logic [31:0] b);
`ifdef DIVZERO_FASTPATH_EN
    return (b == 32'd0) ? 1 : LAT;
`else
    return (b == 32'd0) ? LAT : LAT;
`endif
  endfunction

  task automatic ack_resp();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [3:0] tag, input int hold,
                         output logic [31:0] q, output logic [31:0] r, output logic dz,
                         output logic [3:0] tg, output int lat, output int en_cnt,
                         output int en_at);
    int t0;
    int n;
    q = '0; r = '0; dz = 1'b0; tg = '0; lat = -1; en_cnt = 0; en_at = -1;
    @(negedge clk);
    bus.req_dividend = a;
    bus.req_divisor  = b;
    bus.req_signed   = s;
    bus.req_tag      = tag;
    bus.req_valid    = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_accept", 64'(bus.req_ready), 64'd1);
    t0 = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.div_en) begin
        en_cnt++;
        if (en_at < 0) en_at = cyc - t0;
      end
      if (bus.resp_valid) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat >= 0) begin
      repeat (hold) @(negedge clk);
      q  = bus.resp_quotient;
      r  = bus.resp_remainder;
      dz = bus.resp_divzero;
      tg = bus.resp_tag;
      ack_resp();
      @(negedge clk);
      check("req_ready_after_resp", 64'(bus.req_ready), 64'd1);
    end
  endtask

  task automatic run_and_check(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic [3:0] tag, input int hold,
                               input logic [31:0] eq, input logic [31:0] er, input logic edz);
    logic [31:0] q, r;
    logic        dz;
    logic [3:0]  tg;
    int          lat, en_cnt, en_at, elat;
    run_req(a, b, s, tag, hold, q, r, dz, tg, lat, en_cnt, en_at);
    elat = exp_latency(b);
    check({name, "_quot"}, 64'(q), 64'(eq));
    check({name, "_rem"}, 64'(r), 64'(er));
    check({name, "_divzero"}, 64'(dz), 64'(edz));
    check({name, "_tag"}, 64'(tg), 64'(tag));
    check({name, "_latency"}, 64'(lat), 64'(elat));
    check({name, "_en_count"}, 64'(en_cnt), (elat == 1) ? 64'd0 : 64'd1);
    if (elat != 1) check({name, "_en_cycle"}, 64'(en_at), 64'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [3:0]  tag;
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] a, b, eq, er, snap_q, snap_r;
    logic        s, edz, ready_seen, unstable, resp_seen, en_seen;
    logic [3:0]  tag, snap_tag;
    int          t0, lat, mode;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 4'd1,  32'd14,         32'd2,          1'b0};
    vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 4'd2,  32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 4'd3,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 4'd4,  32'h8000_0000,  32'd0,          1'b0};
    vecs[4]  = '{32'hFFFF_FFFB,  32'd0,          1'b1, 4'd5,  32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
    vecs[5]  = '{32'd5,          32'd0,          1'b0, 4'd6,  32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[6]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 4'd7,  32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[7]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 4'd8,  32'd0,          32'h8000_0000,  1'b0};
    vecs[8]  = '{32'hFFFF_FFF8,  32'hFFFF_FFFD,  1'b1, 4'd9,  32'd2,          32'hFFFF_FFFE,  1'b0};
    vecs[9]  = '{32'd0,          32'd5,          1'b0, 4'd10, 32'd0,          32'd0,          1'b0};
    vecs[10] = '{32'h8000_0000,  32'd0,          1'b1, 4'd11, 32'hFFFF_FFFF,  32'h8000_0000,  1'b1};

    bus.req_valid = 1'b0; bus.req_dividend = '0; bus.req_divisor = '0;
    bus.req_signed = 1'b0; bus.req_tag = '0; bus.resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_div_en", 64'(bus.div_en), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_divzero", 64'(bus.resp_divzero), 64'd0);
    check("rst_resp_quot", 64'(bus.resp_quotient), 64'd0);
    check("rst_resp_rem", 64'(bus.resp_remainder), 64'd0);
    check("rst_resp_tag", 64'(bus.resp_tag), 64'd0);
    check("rst_div_operands", {bus.div_dividend, bus.div_divisor}, 64'd0);

    for (int i = 0; i < 11; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].tag, 0,
                    vecs[i].eq, vecs[i].er, vecs[i].edz);
    end

    // Back-to-back: second request waits while the first response is held.
    @(negedge clk);
    bus.req_dividend = 32'd50; bus.req_divisor = 32'd5; bus.req_signed = 1'b0;
    bus.req_tag = 4'd3; bus.req_valid = 1'b1;
    check("b2b_first_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_dividend = 32'hFFFF_FFF7; bus.req_divisor = 32'd4; bus.req_signed = 1'b1;
    bus.req_tag = 4'd9;
    ready_seen = 1'b0; resp_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        resp_seen = 1'b1;
        break;
      end
      if (bus.req_ready) ready_seen = 1'b1;
    end
    check("b2b_first_resp_seen", 64'(resp_seen), 64'd1);
    snap_q = bus.resp_quotient; snap_r = bus.resp_remainder; snap_tag = bus.resp_tag;
    unstable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.req_ready) ready_seen = 1'b1;
      if (!bus.resp_valid || bus.resp_quotient !== snap_q || bus.resp_remainder !== snap_r ||
          bus.resp_tag !== snap_tag) unstable = 1'b1;
    end
    check("b2b_hold_unstable", 64'(unstable), 64'd0);
    check("b2b_ready_during_first", 64'(ready_seen), 64'd0);
    check("b2b_first_quot", 64'(snap_q), 64'd10);
    check("b2b_first_rem", 64'(snap_r), 64'd0);
    check("b2b_first_tag", 64'(snap_tag), 64'd3);
    ack_resp();
    @(negedge clk);
    check("b2b_second_ready", 64'(bus.req_ready), 64'd1);
    t0 = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = cyc - t0;
        break;
      end
    end
    check("b2b_second_latency", 64'(lat), 64'(LAT));
    check("b2b_second_quot", 64'(bus.resp_quotient), 64'hFFFF_FFFE);
    check("b2b_second_rem", 64'(bus.resp_remainder), 64'hFFFF_FFFF);
    check("b2b_second_tag", 64'(bus.resp_tag), 64'd9);
    ack_resp();

    // Core busy from elsewhere holds the launch in ISSUE.
    stall_busy = 1'b1;
    @(negedge clk);
    bus.req_dividend = 32'd21; bus.req_divisor = 32'd4; bus.req_signed = 1'b0;
    bus.req_tag = 4'd5; bus.req_valid = 1'b1;
    check("stall_accept_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    en_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.div_en) en_seen = 1'b1;
    end
    check("stall_no_en", 64'(en_seen), 64'd0);
    stall_busy = 1'b0;
    #1;
    check("stall_release_en", 64'(bus.div_en), 64'd1);
    t0 = cyc; lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = cyc - t0;
        break;
      end
    end
    check("stall_latency_from_en", 64'(lat), 64'(WIDTH + 2));
    check("stall_quot", 64'(bus.resp_quotient), 64'd5);
    check("stall_rem", 64'(bus.resp_remainder), 64'd1);
    check("stall_tag", 64'(bus.resp_tag), 64'd5);
    ack_resp();

    // A done pulse while idle must not create a response.
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    resp_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid || !bus.req_ready) resp_seen = 1'b1;
    end
    check("stray_done_ignored", 64'(resp_seen), 64'd0);

    // Reset during WAIT abandons the request.
    @(negedge clk);
    bus.req_dividend = 32'd1000; bus.req_divisor = 32'd7; bus.req_signed = 1'b0;
    bus.req_tag = 4'd12; bus.req_valid = 1'b1;
    check("rstwait_accept_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstwait_ready_after", 64'(bus.req_ready), 64'd1);
    resp_seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.resp_valid) resp_seen = 1'b1;
    end
    check("rstwait_no_resp", 64'(resp_seen), 64'd0);
    run_and_check("after_reset", 32'd9, 32'd3, 1'b0, 4'd2, 0, 32'd3, 32'd0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      mode = int'($urandom_range(0, 4));
      case (mode)
        0: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
        1: begin a = $urandom; b = 32'd0; end
        2: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1; end
        3: begin a = ~32'($urandom_range(0, 100)); b = ~32'($urandom_range(0, 9)); end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      s   = 1'($urandom_range(0, 1));
      tag = 4'($urandom);
      ref_div(a, b, s, eq, er, edz);
      run_and_check($sformatf("rand%0d", i), a, b, s, tag, int'($urandom_range(0, 2)), eq, er, edz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
